// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the E stage and the multiply/divide unit.
// The E stage (master) drives requests and operands; the unit (slave)
// returns HI/LO results, a one-cycle valid strobe and the stall request.
interface mult_div_unit_if #(parameter int DATA_W = 32);
  logic              start_mulE;
  logic              start_divE;
  logic              signedE;
  logic [DATA_W-1:0] srcaE;
  logic [DATA_W-1:0] srcbE;
  logic              cancelE;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              hl_valid_o;
  logic              mut_div_stallE;

  modport master (
    output start_mulE, start_divE, signedE, srcaE, srcbE, cancelE,
    input  hi_o, lo_o, hl_valid_o, mut_div_stallE
  );

  modport slave (
    input  start_mulE, start_divE, signedE, srcaE, srcbE, cancelE,
    output hi_o, lo_o, hl_valid_o, mut_div_stallE
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit.
// Divide: 32-step radix-2 restoring divider on operand magnitudes, with the
// quotient/remainder signs fixed up when the result is presented.
// Multiply: single-cycle by default; defining MDU_MULT_PIPE_EN registers
// operands and product (MUL/MDONE states) for a 2-cycle stall instead.
// hi_o/lo_o show the fresh result during the valid cycle and hold it after.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_div_unit_if.slave       bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    DDONE
`ifdef MDU_MULT_PIPE_EN
    ,
    MUL,
    MDONE
`endif
  } state_t;

  function automatic logic [DATA_W-1:0] applySign(input logic [DATA_W-1:0] v,
                                                  input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] mulFull(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sgn);
    logic signed [DATA_W:0]     sa;
    logic signed [DATA_W:0]     sb;
    logic signed [2*DATA_W+1:0] p;
    sa = $signed({sgn & a[DATA_W-1], a});
    sb = $signed({sgn & b[DATA_W-1], b});
    p  = sa * sb;
    return p[2*DATA_W-1:0];
  endfunction

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] remReg, quotReg, divisorReg;
  logic              negQ, negR, divZero;
  logic [DATA_W-1:0] hiReg, loReg;
  logic [DATA_W:0]   stepIn, trial;
  logic              stepOk;
  logic              divStart, mulStart, commit, stall;
  logic [DATA_W-1:0] resHi, resLo;
  logic [2*DATA_W-1:0] prodComb;
`ifdef MDU_MULT_PIPE_EN
  logic [DATA_W-1:0]   srcaP0, srcbP0;
  logic                sgnP0;
  logic [2*DATA_W-1:0] prodP1;
`endif

  assign prodComb = mulFull(bus.srcaE, bus.srcbE, bus.signedE);

  // One restoring-division trial subtraction on the shifted remainder.
  always_comb begin
    stepIn = {remReg, quotReg[DATA_W-1]};
    trial  = stepIn - {1'b0, divisorReg};
    stepOk = (stepIn >= {1'b0, divisorReg});
  end

  // Next-state, stall/valid and presented-result decode; cancel and reset override all.
  always_comb begin
    stateNext = state;
    divStart  = 1'b0;
    mulStart  = 1'b0;
    stall     = 1'b0;
    commit    = 1'b0;
    resHi     = hiReg;
    resLo     = loReg;
    case (state)
      IDLE: begin
        if (bus.start_divE) begin
          divStart  = 1'b1;
          stall     = 1'b1;
          stateNext = DIV;
        end else if (bus.start_mulE) begin
          mulStart = 1'b1;
`ifdef MDU_MULT_PIPE_EN
          stall     = 1'b1;
          stateNext = MUL;
`else
          commit = 1'b1;
          resHi  = prodComb[2*DATA_W-1:DATA_W];
          resLo  = prodComb[DATA_W-1:0];
`endif
        end
      end
      DIV: begin
        stall = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) stateNext = DDONE;
      end
      DDONE: begin
        commit    = 1'b1;
        resHi     = applySign(remReg, negR);
        resLo     = divZero ? '1 : applySign(quotReg, negQ);
        stateNext = IDLE;
      end
`ifdef MDU_MULT_PIPE_EN
      MUL: begin
        stall     = 1'b1;
        stateNext = MDONE;
      end
      MDONE: begin
        commit    = 1'b1;
        resHi     = prodP1[2*DATA_W-1:DATA_W];
        resLo     = prodP1[DATA_W-1:0];
        stateNext = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
    if (bus.cancelE || rst) begin
      stateNext = IDLE;
      divStart  = 1'b0;
      mulStart  = 1'b0;
      stall     = 1'b0;
      commit    = 1'b0;
    end
  end

  assign bus.mut_div_stallE = stall;
  assign bus.hl_valid_o     = commit;
  assign bus.hi_o           = commit ? resHi : hiReg;
  assign bus.lo_o           = commit ? resLo : loReg;

  // Control state: FSM and divide step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      if (divStart)          cnt <= '0;
      else if (state == DIV) cnt <= cnt + 1'b1;
    end
  end

  // HI/LO holding registers, updated only by a committed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (commit) begin
      hiReg <= resHi;
      loReg <= resLo;
    end
  end

  // Divider datapath: latch magnitudes/signs on start, then shift-subtract.
  always_ff @(posedge clk) begin
    if (divStart) begin
      remReg     <= '0;
      quotReg    <= applySign(bus.srcaE, bus.signedE & bus.srcaE[DATA_W-1]);
      divisorReg <= applySign(bus.srcbE, bus.signedE & bus.srcbE[DATA_W-1]);
      negQ       <= bus.signedE & (bus.srcaE[DATA_W-1] ^ bus.srcbE[DATA_W-1]);
      negR       <= bus.signedE & bus.srcaE[DATA_W-1];
      divZero    <= (bus.srcbE == '0);
    end else if (state == DIV) begin
      remReg  <= stepOk ? trial[DATA_W-1:0] : stepIn[DATA_W-1:0];
      quotReg <= {quotReg[DATA_W-2:0], stepOk};
    end
  end

`ifdef MDU_MULT_PIPE_EN
  // Stage p0: operand capture in the start cycle.
  always_ff @(posedge clk) begin
    if (mulStart) begin
      srcaP0 <= bus.srcaE;
      srcbP0 <= bus.srcbE;
      sgnP0  <= bus.signedE;
    end
  end

  // Stage p1: product register, presented in MDONE.
  always_ff @(posedge clk) begin
    if (state == MUL) prodP1 <= mulFull(srcaP0, srcbP0, sgnP0);
  end
`else
  logic unusedMulStart;
  assign unusedMulStart = mulStart;
`endif
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start_mulE  input  1  MULT/MULTU in E stage.
REQ-005 SHALL have port: start_divE  input  1  DIV/DIVU in E stage.
REQ-006 SHALL have port: signedE  input  1  1 selects signed (MULT/DIV), 0 selects unsigned.
REQ-007 SHALL have port: srcaE  input  32  rs operand (dividend or multiplicand).
REQ-008 SHALL have port: srcbE  input  32  rt operand (divisor or multiplier).
REQ-009 SHALL have port: cancelE  input  1  abort the operation in flight (exception or flush).
REQ-010 SHALL have port: hi_o  output  32  HI result (product[63:32] or remainder).
REQ-011 SHALL have port: lo_o  output  32  LO result (product[31:0] or quotient).
REQ-012 SHALL have port: hl_valid_o  output  1  hi_o/lo_o valid this cycle; drives the HI/LO write.
REQ-013 SHALL have port: mut_div_stallE  output  1  holds E stage and earlier while set; feeds the hazard unit.

Function
REQ-014 SHALL implement the states IDLE, DIV, DDONE, plus MUL and MDONE when MDU_MULT_PIPE_EN is defined.
REQ-015 IDLE with start_divE=1 and cancelE=0 SHALL, in the same cycle, drive mut_div_stallE=1, latch operand magnitudes and result signs, clear the iteration counter, and go to DIV.
REQ-016 DIV SHALL perform one radix-2 restoring step per cycle (64-bit remainder/quotient shift register) with mut_div_stallE=1, and SHALL go to DDONE after exactly 32 steps.
REQ-017 DIV latency SHALL be 33 stall cycles (start cycle plus 32 steps), then one DDONE cycle with mut_div_stallE=0 and hl_valid_o=1.
REQ-018 DDONE SHALL return to IDLE unconditionally, and start_divE seen in DDONE SHALL NOT restart the unit because it is the same instruction.
REQ-019 Signed divide SHALL negate the quotient when operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-020 Divide by zero (srcbE=0, signed or unsigned) SHALL take the full latency and produce LO=0xFFFFFFFF and HI=srcaE.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-022 Multiply SHALL produce the 64-bit product, sign-extended when signedE=1 and zero-extended when signedE=0, as {hi_o, lo_o}.
REQ-023 hi_o/lo_o SHALL hold their last valid result until the next valid result.
REQ-024 hl_valid_o SHALL be a single-cycle pulse per completed operation.
REQ-025 cancelE=1 in any state SHALL force mut_div_stallE=0 and hl_valid_o=0 combinationally, go to IDLE on the next edge, and leave hi_o/lo_o unchanged.
REQ-026 If start_mulE and start_divE are both set, divide SHALL take priority.
REQ-027 Start requests received outside IDLE SHALL be ignored.
REQ-028 A new divide arriving in the IDLE cycle right after DDONE SHALL start normally, with no bubble added by this unit.

Reset
REQ-029 rst=1 SHALL force state IDLE, the counter to 0, hi_o=0, lo_o=0, hl_valid_o=0 and mut_div_stallE=0 on the next edge.
REQ-030 rst mid-divide SHALL abandon the operation with no hl_valid_o pulse.
REQ-031 While rst=1, mut_div_stallE SHALL read 0.

Configuration
REQ-032 The macro MDU_MULT_PIPE_EN SHALL select multiply timing.
REQ-033 With MDU_MULT_PIPE_EN undefined, multiply SHALL be combinational: in the start_mulE cycle hl_valid_o=1, mut_div_stallE=0, and the result appears on hi_o/lo_o in that cycle (registered for holding afterwards).
REQ-034 With MDU_MULT_PIPE_EN defined, the start cycle SHALL register the operands with mut_div_stallE=1 and go to MUL.
REQ-035 MUL SHALL register the product with mut_div_stallE=1 and go to MDONE.
REQ-036 MDONE SHALL drive hl_valid_o=1 and mut_div_stallE=0, then return to IDLE, giving 2 stall cycles in total.

Verification
REQ-037 DIVU 100/7, start_divE held while stalled -> mut_div_stallE high for 33 cycles, then one cycle with hl_valid_o=1, LO=14, HI=2.
REQ-038 DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678 after the full 33-cycle stall.
REQ-040 MULT 0xFFFFFFFF*3 -> {HI,LO}=0xFFFFFFFF_FFFFFFFD, and MULTU with the same operands -> {HI,LO}=0x00000002_FFFFFFFD, with 0 stall cycles (macro off) or 2 stall cycles (macro on).
REQ-041 cancelE=1 on DIV step 10 -> stall drops in the same cycle, no hl_valid_o pulse, HI/LO unchanged, and the next DIVU 9/3 gives LO=3, HI=0.
REQ-042 rst=1 on DIV step 20 -> all outputs 0 next cycle, and back-to-back DIVU 8/2 then DIVU 9/4 -> results LO=4,HI=0 then LO=2,HI=1 with no extra bubble.
